vga_timing_gen: RTL and testbench

//  Upstream raster generator for the sprite renderer: produces pixel coords X/Y, display_on and VGA syncs.

---
 rtl/vga_timing_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the sprite renderer.
// Produces pixel coordinates, display_on, VGA sync/blank and line/frame strobes.
// Each axis is sequenced by a phase FSM (ACTIVE->FRONT->SYNC->BACK).
// The free-running counters give X/Y; the FSMs give the blank and sync windows.
// All outputs are registered from the pre-increment state (1 cycle latency).
// Optional macro VGA_SYNC_DELAY_EN: VGA_HS/VGA_VS/VGA_BLANK_N are passed
// through a SYNC_DELAY-deep shift register so they line up with the
// renderer's RGB pipeline.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SYNC_DELAY = 2
) (
    input  logic               VGA_clk,
    input  logic               rst,
    output logic signed [31:0] X,
    output logic signed [31:0] Y,
    output logic               display_on,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N,
    output logic               line_tick,
    output logic               frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = SYNC_DELAY;
`else
    localparam int DLY = 0;
`endif

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACTIVE_M1 = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_FRONT_M1  = HW'(H_FRONT - 1);
    localparam logic [HW-1:0] H_SYNC_M1   = HW'(H_SYNC - 1);
    localparam logic [HW-1:0] H_BACK_M1   = HW'(H_BACK - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACTIVE_VW = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACTIVE_M1 = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_FRONT_M1  = VW'(V_FRONT - 1);
    localparam logic [VW-1:0] V_SYNC_M1   = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] V_BACK_M1   = VW'(V_BACK - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [HW-1:0] h_seg_q, h_seg_d, h_len_m1;
    logic [VW-1:0] v_seg_q, v_seg_d, v_len_m1;
    phase_e        h_phase_q, h_phase_d;
    phase_e        v_phase_q, v_phase_d;
    logic          h_wrap;
    logic          v_wrap;

    logic [HW-1:0] x_q;
    logic [VW-1:0] y_q;
    logic          disp_q;
    logic          hs_q;
    logic          vs_q;
    logic          line_q;
    logic          frame_q;

    // Pixel/line counters: h wraps every line, v steps on the h wrap
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Horizontal phase FSM: next phase when the segment counter hits its last count
    always_comb begin
        h_phase_d = h_phase_q;
        h_seg_d   = h_seg_q + HW'(1);
        case (h_phase_q)
            PH_ACTIVE: h_len_m1 = H_ACTIVE_M1;
            PH_FRONT:  h_len_m1 = H_FRONT_M1;
            PH_SYNC:   h_len_m1 = H_SYNC_M1;
            default:   h_len_m1 = H_BACK_M1;
        endcase
        if (h_seg_q == h_len_m1) begin
            h_seg_d = '0;
            case (h_phase_q)
                PH_ACTIVE: h_phase_d = PH_FRONT;
                PH_FRONT:  h_phase_d = PH_SYNC;
                PH_SYNC:   h_phase_d = PH_BACK;
                default:   h_phase_d = PH_ACTIVE;
            endcase
        end
    end

    // Vertical phase FSM: same sequence, but only moves on the line wrap
    always_comb begin
        v_phase_d = v_phase_q;
        v_seg_d   = v_seg_q;
        case (v_phase_q)
            PH_ACTIVE: v_len_m1 = V_ACTIVE_M1;
            PH_FRONT:  v_len_m1 = V_FRONT_M1;
            PH_SYNC:   v_len_m1 = V_SYNC_M1;
            default:   v_len_m1 = V_BACK_M1;
        endcase
        if (h_wrap) begin
            v_seg_d = v_seg_q + VW'(1);
            if (v_seg_q == v_len_m1) begin
                v_seg_d = '0;
                case (v_phase_q)
                    PH_ACTIVE: v_phase_d = PH_FRONT;
                    PH_FRONT:  v_phase_d = PH_SYNC;
                    PH_SYNC:   v_phase_d = PH_BACK;
                    default:   v_phase_d = PH_ACTIVE;
                endcase
            end
        end
    end

    // Counter and FSM state registers; reset aborts the frame and restarts at (0,0)
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_seg_q   <= '0;
            v_seg_q   <= '0;
            h_phase_q <= PH_ACTIVE;
            v_phase_q <= PH_ACTIVE;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            h_seg_q   <= h_seg_d;
            v_seg_q   <= v_seg_d;
            h_phase_q <= h_phase_d;
            v_phase_q <= v_phase_d;
        end
    end

    // Output registers, sampled from the pre-increment counters and phases
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            disp_q  <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            x_q     <= h_cnt_q;
            y_q     <= v_cnt_q;
            disp_q  <= (h_phase_q == PH_ACTIVE) && (v_phase_q == PH_ACTIVE);
            hs_q    <= (h_phase_q == PH_SYNC) ? HS_POL : ~HS_POL;
            vs_q    <= (v_phase_q == PH_SYNC) ? VS_POL : ~VS_POL;
            line_q  <= h_wrap;
            frame_q <= (h_cnt_q == '0) && (v_cnt_q == V_ACTIVE_VW);
        end
    end

    // Coordinates are plain unsigned counts zero-extended into the signed ports
    assign X          = {{(32 - HW){1'b0}}, x_q};
    assign Y          = {{(32 - VW){1'b0}}, y_q};
    assign display_on = disp_q;
    assign line_tick  = line_q;
    assign frame_tick = frame_q;
    assign VGA_SYNC_N = 1'b0;

    generate
        if (DLY > 0) begin : g_sync_dly
            logic [DLY-1:0] hs_dly_q;
            logic [DLY-1:0] vs_dly_q;
            logic [DLY-1:0] blank_dly_q;

            // Shift sync/blank along so they track the renderer's pixel pipeline
            always_ff @(posedge VGA_clk or posedge rst) begin
                if (rst) begin
                    hs_dly_q    <= {DLY{~HS_POL}};
                    vs_dly_q    <= {DLY{~VS_POL}};
                    blank_dly_q <= '0;
                end else begin
                    hs_dly_q[0]    <= hs_q;
                    vs_dly_q[0]    <= vs_q;
                    blank_dly_q[0] <= disp_q;
                    for (int i = 1; i < DLY; i++) begin
                        hs_dly_q[i]    <= hs_dly_q[i-1];
                        vs_dly_q[i]    <= vs_dly_q[i-1];
                        blank_dly_q[i] <= blank_dly_q[i-1];
                    end
                end
            end

            assign VGA_HS      = hs_dly_q[DLY-1];
            assign VGA_VS      = vs_dly_q[DLY-1];
            assign VGA_BLANK_N = blank_dly_q[DLY-1];
        end else begin : g_sync_direct
            assign VGA_HS      = hs_q;
            assign VGA_VS      = vs_q;
            assign VGA_BLANK_N = disp_q;
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: line timing on the 640x480 instance,
// frame/wrap/mid-frame reset on a reduced-size instance (56x28 total).
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    // reduced-size geometry for frame-level checks
    localparam int SHA = 40, SHF = 4, SHS = 8, SHB = 4, SHT = 56;
    localparam int SVA = 20, SVF = 2, SVS = 2, SVB = 4, SVT = 28;
    localparam int SFRAME = SHT * SVT;

    logic VGA_clk = 1'b0;
    logic rst     = 1'b1;
    logic rst_s   = 1'b1;

    logic signed [31:0] x, y, xs, ys;
    logic disp, hs, vs, blank_n, sync_n, ltick, ftick;
    logic disp_s, hs_s, vs_s, blank_n_s, sync_n_s, ltick_s, ftick_s;

    int checks = 0;
    int passed = 0;

    always #20 VGA_clk = ~VGA_clk;

    vga_timing_gen dut (
        .VGA_clk(VGA_clk), .rst(rst), .X(x), .Y(y), .display_on(disp),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n),
        .line_tick(ltick), .frame_tick(ftick)
    );

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) dut_s (
        .VGA_clk(VGA_clk), .rst(rst_s), .X(xs), .Y(ys), .display_on(disp_s),
        .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(blank_n_s), .VGA_SYNC_N(sync_n_s),
        .line_tick(ltick_s), .frame_tick(ftick_s)
    );

    task automatic step();
        @(posedge VGA_clk);
        @(negedge VGA_clk);
    endtask

    function automatic int phase_of(int c, int a, int f, int s);
        if (c < a) return 0;
        else if (c < a + f) return 1;
        else if (c < a + f + s) return 2;
        else return 3;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rst_s = 1'b1;
        repeat (5) step();
        checks++; if (x !== 0) $display("FAIL reset_x: got %0d expected 0", x); else passed++;
        checks++; if (y !== 0) $display("FAIL reset_y: got %0d expected 0", y); else passed++;
        checks++; if (disp !== 1'b0) $display("FAIL reset_disp: got %b expected 0", disp); else passed++;
        checks++; if (blank_n !== 1'b0) $display("FAIL reset_blank_n: got %b expected 0", blank_n); else passed++;
        checks++; if (hs !== 1'b1 || vs !== 1'b1) $display("FAIL reset_sync: got hs=%b vs=%b expected 1 1", hs, vs); else passed++;
        checks++; if (ltick !== 1'b0 || ftick !== 1'b0) $display("FAIL reset_ticks: got %b%b expected 00", ltick, ftick); else passed++;
        checks++; if (sync_n !== 1'b0) $display("FAIL reset_sync_n: got %b expected 0", sync_n); else passed++;
        rst = 1'b0;
        step();
        checks++; if (x !== 0 || y !== 0) $display("FAIL first_xy: got (%0d,%0d) expected (0,0)", x, y); else passed++;
        checks++; if (disp !== 1'b1) $display("FAIL first_disp: got %b expected 1", disp); else passed++;
        checks++; if (blank_n !== (LAG == 0)) $display("FAIL first_blank_n: got %b expected %b", blank_n, (LAG == 0)); else passed++;
        $display("test_reset done: checks=%0d passed=%0d", checks, passed);
    endtask

    task automatic test_line();
        int xerr = 0, perr = 0, fall_x = -1, hs_cnt = 0, hs_first = -1, lt_cnt = 0, lt_x = -1;
        for (int i = 0; i < 800; i++) begin
            if (x !== i) xerr++;
            if (int'(dut.h_phase_q) != phase_of((i + 1) % 800, 640, 16, 96)) perr++;
            if (disp === 1'b0 && fall_x < 0) fall_x = x;
            if (hs === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = x;
            end
            if (ltick === 1'b1) begin
                lt_cnt++;
                lt_x = x;
            end
            step();
        end
        checks++; if (xerr != 0) $display("FAIL line_x_seq: got %0d wrong samples expected 0", xerr); else passed++;
        checks++; if (perr != 0) $display("FAIL line_h_phase: got %0d disagreements expected 0", perr); else passed++;
        checks++; if (fall_x != 640) $display("FAIL line_disp_fall: got X=%0d expected 640", fall_x); else passed++;
        checks++; if (hs_cnt != 96) $display("FAIL line_hs_width: got %0d expected 96", hs_cnt); else passed++;
        checks++; if (hs_first != 656 + LAG) $display("FAIL line_hs_start: got X=%0d expected %0d", hs_first, 656 + LAG); else passed++;
        checks++; if (lt_cnt != 1 || lt_x != 799) $display("FAIL line_tick: got count=%0d X=%0d expected 1 at 799", lt_cnt, lt_x); else passed++;
        checks++; if (x !== 0 || y !== 1) $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", x, y); else passed++;
        $display("test_line done: checks=%0d passed=%0d", checks, passed);
    endtask

    task automatic test_sync_delay();
        int n = 0, lag = 0;
        while (x !== 640 && n < 2000) begin step(); n++; end
        checks++; if (n >= 2000) $display("FAIL dly_wait640: got timeout expected X=640"); else passed++;
        checks++; if (disp !== 1'b0) $display("FAIL dly_disp640: got %b expected 0", disp); else passed++;
        while (blank_n !== 1'b0 && lag < 10) begin step(); lag++; end
        checks++; if (lag != LAG) $display("FAIL dly_blank_lag: got %0d expected %0d", lag, LAG); else passed++;
        n = 0;
        while (x !== 656 && n < 2000) begin step(); n++; end
        checks++; if (n >= 2000) $display("FAIL dly_wait656: got timeout expected X=656"); else passed++;
        lag = 0;
        while (hs !== 1'b0 && lag < 10) begin step(); lag++; end
        checks++; if (lag != LAG) $display("FAIL dly_hs_lag: got %0d expected %0d", lag, LAG); else passed++;
        checks++; if (x !== 656 + LAG || y !== 1) $display("FAIL dly_xy: got (%0d,%0d) expected (%0d,1)", x, y, 656 + LAG); else passed++;
        $display("test_sync_delay done: checks=%0d passed=%0d", checks, passed);
    endtask

    task automatic test_frame();
        int perr = 0, derr = 0, pherr = 0, vs_cnt = 0, vs_fx = -1, vs_fy = -1;
        int ft_cnt = 0, ft_x = -1, ft_y = -1, lt_cnt = 0;
        rst_s = 1'b0;
        step();
        for (int i = 0; i < SFRAME; i++) begin
            int ex, ey, ih, iv;
            ex = i % SHT;
            ey = i / SHT;
            ih = (ex + 1) % SHT;
            iv = (ex == SHT - 1) ? (ey + 1) % SVT : ey;
            if (xs !== ex || ys !== ey) perr++;
            if (disp_s !== (ex < SHA && ey < SVA)) derr++;
            if (int'(dut_s.h_phase_q) != phase_of(ih, SHA, SHF, SHS)) pherr++;
            if (int'(dut_s.v_phase_q) != phase_of(iv, SVA, SVF, SVS)) pherr++;
            if (vs_s === 1'b0) begin
                vs_cnt++;
                if (vs_fx < 0) begin vs_fx = xs; vs_fy = ys; end
            end
            if (ftick_s === 1'b1) begin ft_cnt++; ft_x = xs; ft_y = ys; end
            if (ltick_s === 1'b1) lt_cnt++;
            step();
        end
        checks++; if (perr != 0) $display("FAIL frame_xy_seq: got %0d wrong samples expected 0", perr); else passed++;
        checks++; if (derr != 0) $display("FAIL frame_disp: got %0d wrong samples expected 0", derr); else passed++;
        checks++; if (pherr != 0) $display("FAIL frame_phase: got %0d disagreements expected 0", pherr); else passed++;
        checks++; if (vs_cnt != 2 * SHT) $display("FAIL frame_vs_width: got %0d expected %0d", vs_cnt, 2 * SHT); else passed++;
        checks++; if (vs_fx != LAG || vs_fy != 22) $display("FAIL frame_vs_start: got (%0d,%0d) expected (%0d,22)", vs_fx, vs_fy, LAG); else passed++;
        checks++; if (ft_cnt != 1 || ft_x != 0 || ft_y != SVA) $display("FAIL frame_tick: got count=%0d at (%0d,%0d) expected 1 at (0,20)", ft_cnt, ft_x, ft_y); else passed++;
        checks++; if (lt_cnt != SVT) $display("FAIL frame_line_ticks: got %0d expected %0d", lt_cnt, SVT); else passed++;
        $display("test_frame done: checks=%0d passed=%0d", checks, passed);
    endtask

    task automatic test_wrap();
        int n = 0, gap = 0;
        checks++; if (xs !== 0 || ys !== 0) $display("FAIL wrap_xy: got (%0d,%0d) expected (0,0)", xs, ys); else passed++;
        checks++; if (int'(dut_s.h_phase_q) != 0 || int'(dut_s.v_phase_q) != 0)
            $display("FAIL wrap_phase: got h=%0d v=%0d expected 0 0", int'(dut_s.h_phase_q), int'(dut_s.v_phase_q)); else passed++;
        while (ftick_s !== 1'b1 && n < 2 * SFRAME) begin step(); n++; end
        checks++; if (n >= 2 * SFRAME) $display("FAIL wrap_tick_wait: got timeout expected frame_tick"); else passed++;
        do begin step(); gap++; end while (ftick_s !== 1'b1 && gap < 2 * SFRAME);
        checks++; if (gap != SFRAME) $display("FAIL wrap_tick_period: got %0d expected %0d", gap, SFRAME); else passed++;
        $display("test_wrap done: checks=%0d passed=%0d", checks, passed);
    endtask

    task automatic test_mid_reset();
        int n = 0, stray = 0;
        while (!(xs === 20 && ys === 10) && n < 2 * SFRAME) begin step(); n++; end
        checks++; if (n >= 2 * SFRAME) $display("FAIL mid_wait: got timeout expected (20,10)"); else passed++;
        rst_s = 1'b1;
        #1;
        checks++; if (xs !== 0 || ys !== 0 || disp_s !== 1'b0)
            $display("FAIL mid_async: got (%0d,%0d) disp=%b expected (0,0) disp=0", xs, ys, disp_s); else passed++;
        checks++; if (hs_s !== 1'b1 || vs_s !== 1'b1 || blank_n_s !== 1'b0)
            $display("FAIL mid_async_sync: got hs=%b vs=%b blank_n=%b expected 1 1 0", hs_s, vs_s, blank_n_s); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ltick_s !== 1'b0 || ftick_s !== 1'b0) stray++;
        end
        rst_s = 1'b0;
        step();
        if (ltick_s !== 1'b0 || ftick_s !== 1'b0) stray++;
        checks++; if (xs !== 0 || ys !== 0 || disp_s !== 1'b1)
            $display("FAIL mid_restart: got (%0d,%0d) disp=%b expected (0,0) disp=1", xs, ys, disp_s); else passed++;
        step();
        if (ltick_s !== 1'b0 || ftick_s !== 1'b0) stray++;
        checks++; if (xs !== 1 || ys !== 0) $display("FAIL mid_next: got (%0d,%0d) expected (1,0)", xs, ys); else passed++;
        checks++; if (stray != 0) $display("FAIL mid_stray_tick: got %0d ticks expected 0", stray); else passed++;
        $display("test_mid_reset done: checks=%0d passed=%0d", checks, passed);
    endtask

    initial begin
        test_reset();
        test_line();
        test_sync_delay();
        test_frame();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
